// File: rtl/spi_slave_responder.sv
// SPI responder on the system clock: oversamples sclk/mosi/cs_n, receives one DATA_W frame
// MSB-first while shifting out a preloaded reply, in any CPOL/CPHA mode.
module spi_slave_responder #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs_n,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              done,
    output logic              underrun,
    output logic              abort,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_DONE    = 2'd2,
        S_WAIT_CS = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   cs_dly_q, cs_dly_d;

    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              first_q, first_d;
    logic              underrun_q, underrun_d;

    logic sclk_s, mosi_s, cs_s;
    logic lead_edge, trail_edge, cs_fall, frame_start, accept, cnt_full;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    // Edge polarity is judged against the cpol latched at frame start.
    assign lead_edge   = (sclk_s != sclk_dly_q) && (sclk_dly_q == cpol_q);
    assign trail_edge  = (sclk_s != sclk_dly_q) && (sclk_s == cpol_q);
    assign cs_fall     = !cs_s && cs_dly_q;
    assign frame_start = (state_q == S_IDLE) && cs_fall;
    assign accept      = tx_valid && !buf_full_q;
    assign cnt_full    = (bit_cnt_q == CNT_W'(DATA_W));

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        sclk_dly_d  = sclk_s;
        cs_dly_d    = cs_s;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (cs_fall) state_d = S_ACTIVE;
            S_ACTIVE: begin
                if (cnt_full)  state_d = S_DONE;
                else if (cs_s) state_d = S_IDLE;
            end
            S_DONE:    state_d = S_WAIT_CS;
            S_WAIT_CS: if (cs_s) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        miso      = (state_q == S_ACTIVE) ? tx_shift_q[DATA_W-1] : 1'b0;
        miso_oe   = (state_q != S_IDLE);
        rx_valid  = (state_q == S_DONE);
        done      = (state_q == S_DONE);
        abort     = (state_q == S_ACTIVE) && cs_s && !cnt_full;
        tx_ready  = !buf_full_q;
        underrun  = underrun_q;
        rx_data   = rx_data_q;
        dbg_state = state_q;
    end

    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        first_d    = first_q;
        underrun_d = underrun_q;

        if (accept) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
            underrun_d = 1'b0;
        end

        // A word accepted on the start cycle lands in the buffer for the next frame.
        if (frame_start) begin
            cpol_d     = cpol;
            cpha_d     = cpha;
            bit_cnt_d  = '0;
            first_d    = 1'b1;
            rx_shift_d = '0;
            if (buf_full_q) begin
                tx_shift_d = buf_q;
                buf_full_d = 1'b0;
            end else begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end
        end

        if (state_q == S_ACTIVE && !cnt_full) begin
            if (!cpha_q) begin
                if (lead_edge) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                end
                if (trail_edge) tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
            end else begin
                // The MSB is already on miso, so the first leading edge must not shift.
                if (lead_edge) begin
                    if (first_q) first_d = 1'b0;
                    else         tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                end
                if (trail_edge) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                end
            end
        end

        if (state_q == S_ACTIVE && cnt_full) rx_data_d = rx_shift_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            first_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            cs_dly_q    <= cs_dly_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            first_q     <= first_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a bit-banged SPI master drives frames; received words are
// checked by a monitor against an expected queue, reply words are checked by the driver.
module tb_spi_slave_responder;

    localparam int W    = 32;
    localparam int HALF = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1;
    logic         miso, miso_oe, tx_ready, rx_valid, done, underrun, abort;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic [W-1:0] rx_data;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int abort_cnt = 0;
    logic [W-1:0] exp_q[$];

    spi_slave_responder #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .sclk(sclk), .mosi(mosi),
        .cs_n(cs_n), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .done(done),
        .underrun(underrun), .abort(abort), .dbg_state(dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rx_valid || done) begin
            rx_cnt++;
            check("rx_valid_with_done", W'({rx_valid, done}), W'(2'b11));
            if (exp_q.size() == 0) begin
                check("rx_unexpected", rx_data, 32'hxxxx_xxxx);
            end else begin
                check("rx_data", rx_data, exp_q.pop_front());
            end
        end
        if (abort) abort_cnt++;
    end

    // Drivers
    task automatic push_tx(input logic [W-1:0] w);
        int n = 0;
        @(negedge clk);
        tx_data  = w;
        tx_valid = 1'b1;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("tx_accept_timeout", W'(tx_ready), W'(1));
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic spi_frame(input logic pol, input logic pha, input logic [W-1:0] mo,
                             input int nbits, input bit rst_mid, output logic [W-1:0] mi);
        mi = '0;
        @(negedge clk);
        cpol = pol; cpha = pha; sclk = pol; cs_n = 1'b1; mosi = 1'b0;
        repeat (4) @(negedge clk);
        cs_n = 1'b0;
        if (!pha) mosi = mo[W-1];
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sclk = ~pol;
            if (!pha) mi[W-1-i] = miso;
            else      mosi = mo[W-1-i];
            if (i == 0) check("miso_oe_active", W'(miso_oe), W'(1));
            repeat (HALF) @(negedge clk);
            sclk = pol;
            if (pha) mi[W-1-i] = miso;
            else if (i < W-1) mosi = mo[W-2-i];
            repeat (HALF) @(negedge clk);
        end
        if (rst_mid) begin
            reset = 1'b0;
            repeat (2) @(negedge clk);
        end
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_miso"},     W'(miso),      W'(0));
        check({tag, "_miso_oe"},  W'(miso_oe),   W'(0));
        check({tag, "_tx_ready"}, W'(tx_ready),  W'(1));
        check({tag, "_rx_data"},  rx_data,       W'(0));
        check({tag, "_rx_valid"}, W'(rx_valid),  W'(0));
        check({tag, "_done"},     W'(done),      W'(0));
        check({tag, "_underrun"}, W'(underrun),  W'(0));
        check({tag, "_abort"},    W'(abort),     W'(0));
        check({tag, "_state"},    W'(dbg_state), W'(0));
    endtask

    // Directed sequence
    initial begin
        logic [W-1:0] mi;
        int n;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Modes 1, 2, 3 round trip
        for (int m = 1; m < 4; m++) begin
            push_tx(32'h8000_0001);
            exp_q.push_back(32'h0000_FFFF);
            spi_frame(m[1], m[0], 32'h0000_FFFF, W, 1'b0, mi);
            check($sformatf("mode%0d_miso_word", m), mi, 32'h8000_0001);
        end

        // Mode 0
        push_tx(32'hA5A5_1234);
        check("tx_ready_full", W'(tx_ready), W'(0));
        exp_q.push_back(32'hDEAD_BEEF);
        spi_frame(1'b0, 1'b0, 32'hDEAD_BEEF, W, 1'b0, mi);
        check("mode0_miso_word", mi, 32'hA5A5_1234);
        check("tx_ready_consumed", W'(tx_ready), W'(1));
        check("rx_count_modes", W'(rx_cnt), W'(4));

        // Abort after 10 bits
        push_tx(32'h5555_AAAA);
        spi_frame(1'b0, 1'b0, 32'h1230_0000, 10, 1'b0, mi);
        check("abort_count", W'(abort_cnt), W'(1));
        check("abort_rx_count", W'(rx_cnt), W'(4));
        check("abort_rx_data_kept", rx_data, 32'hDEAD_BEEF);
        check("abort_underrun", W'(underrun), W'(0));

        // Underrun: empty buffer
        exp_q.push_back(32'h0F0F_0F0F);
        spi_frame(1'b0, 1'b0, 32'h0F0F_0F0F, W, 1'b0, mi);
        check("underrun_miso_word", mi, 32'h0);
        check("underrun_set", W'(underrun), W'(1));
        push_tx(32'h1111_2222);
        check("underrun_cleared", W'(underrun), W'(0));
        exp_q.push_back(32'hF0E1_D2C3);
        spi_frame(1'b0, 1'b1, 32'hF0E1_D2C3, W, 1'b0, mi);
        check("mode1_after_underrun", mi, 32'h1111_2222);

        // Reset at bit 16 (empty buffer, so underrun is set beforehand)
        spi_frame(1'b0, 1'b0, 32'hFFFF_FFFF, 16, 1'b1, mi);
        check_reset_values("midreset");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        push_tx(32'hCAFE_F00D);
        exp_q.push_back(32'h1234_5678);
        spi_frame(1'b0, 1'b0, 32'h1234_5678, W, 1'b0, mi);
        check("post_reset_miso_word", mi, 32'hCAFE_F00D);
        check("rx_count_post_reset", W'(rx_cnt), W'(7));

        // tx_valid on the frame-start cycle with a full buffer
        push_tx(32'h0BAD_C0DE);
        exp_q.push_back(32'h1357_9BDF);
        fork
            spi_frame(1'b0, 1'b0, 32'h1357_9BDF, W, 1'b0, mi);
            begin
                @(negedge cs_n);
                repeat (2) @(negedge clk);
                check("tx_ready_at_start", W'(tx_ready), W'(0));
                tx_data  = 32'h5EED_1234;
                tx_valid = 1'b1;
                n = 0;
                while (!tx_ready && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("tx_ready_after_start", W'(tx_ready), W'(1));
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        check("simul_miso_word", mi, 32'h0BAD_C0DE);
        check("simul_word_held", W'(tx_ready), W'(0));
        exp_q.push_back(32'h2468_ACE0);
        spi_frame(1'b1, 1'b1, 32'h2468_ACE0, W, 1'b0, mi);
        check("held_word_sent", mi, 32'h5EED_1234);
        check("tx_ready_final", W'(tx_ready), W'(1));

        // Final report
        repeat (10) @(negedge clk);
        check("rx_count_total", W'(rx_cnt), W'(9));
        check("abort_count_total", W'(abort_cnt), W'(1));
        check("exp_q_empty", W'(exp_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
